pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: payload width, carried unmodified; legal range 1..512.
REQ-002 Parameter CTRL_W, default 8: control-field width (regwrite/memwrite/branch class bits), forced to zero in bubbles; legal range 1..64.
REQ-003 Parameter CNT_W, default 16: stall-counter width; legal range 4..32.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetl  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous kill of all held and incoming entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage accepts an entry this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control field.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 out_valid  output  1  downstream entry present.
REQ-012 out_ready  input  1  downstream accepts; low means stall.
REQ-013 out_ctrl  output  CTRL_W  control field; all-zero whenever out_valid=0.
REQ-014 out_data  output  DATA_W  payload; holds its last value when out_valid=0.
REQ-015 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Transfer in: accept on a rising edge where in_valid=1 and in_ready=1; transfer out: complete on a rising edge where out_valid=1 and out_ready=1.
REQ-017 Latency: an entry accepted at edge N is presented on out_* after edge N (one cycle); there is no combinational in->out data path.
REQ-018 Ordering: entries leave in acceptance order; none dropped or duplicated except by flush.
REQ-019 Bubble: out_ctrl is registered as zero whenever the stage holds no valid entry; it is never a don't-care.
REQ-020 Flush: at a rising edge with flush=1, out_valid and every internal valid clear, out_ctrl goes to zero, and any in_valid&in_ready transfer in that cycle is discarded.
REQ-021 Flush with a simultaneous out transfer: the transfer counts as completed; downstream owns the kill decision.
REQ-022 stall_cnt: increments by 1 per stall cycle, saturates at 2^CNT_W-1 (no wrap), is unaffected by flush, and clears only on reset.
REQ-023 Full throughput: with in_valid=1 and out_ready=1 held, one entry per cycle, with no bubbles after the first.

Reset
REQ-024 While resetl=0, asynchronously: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, all internal valids and buffer contents=0.
REQ-025 in_ready reads 1 during and immediately after reset.
REQ-026 Reset asserted mid-transfer abandons the entry; after release, the first accepted entry is the first emitted.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN absent: single register; in_ready = !out_valid | out_ready (combinational from out_ready).
REQ-028 Macro PIPE_STAGE_SKID_EN defined: in_ready is registered with no combinational path from out_ready, using a two-entry skid buffer with states EMPTY, MAIN, MAIN_SKID.
REQ-029 EMPTY -> MAIN on in transfer.
REQ-030 MAIN holds on simultaneous in and out transfer; -> EMPTY on out transfer alone; -> MAIN_SKID on in transfer while out_ready=0.
REQ-031 MAIN_SKID: in_ready=0; -> MAIN on out transfer, with the skid entry promoted to out_* at the same edge.
REQ-032 Flush returns any skid state to EMPTY.
REQ-033 With PIPE_STAGE_SKID_EN, in_ready = 1 in EMPTY and MAIN, and full throughput (REQ-023) still holds.

Verification
REQ-034 Streaming: DATA_W=64, 8 entries 0x1..0x8 back-to-back, out_ready=1 -> out_data 0x1..0x8 on consecutive cycles starting 1 cycle after the first accept; stall_cnt=0.
REQ-035 Stall: entry 0xA5, out_ready=0 for 3 cycles then 1 -> out_data holds 0xA5 for 4 cycles; stall_cnt=3; skid build: a second entry 0x5A is held in the skid buffer, in_ready=0, and 0x5A emerges the cycle after 0xA5.
REQ-036 Flush: stage holding ctrl=0xFF, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, and the incoming entry never appears.
REQ-037 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 0xF.
REQ-038 Async reset: resetl low mid-cycle while full -> out_valid, out_ctrl, out_data, stall_cnt read 0 before the next edge; in_ready=1.
REQ-039 Random valid/ready (10k cycles, both macro settings) -> scoreboard order and content match, and out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with a registered bubble control field and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid buffer that registers in_ready.
`timescale 1ns/1ps

module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [CNT_W-1:0] stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {EMPTY, MAIN, MAIN_SKID} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = (state_q != EMPTY) && out_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = MAIN;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        MAIN: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (out_xfer) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end else if (in_xfer) begin
            state_d     = MAIN_SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end
        end
        MAIN_SKID: begin
          // The skid entry is promoted straight into the output register on drain.
          if (out_xfer) begin
            state_d     = MAIN;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
    in_ready_d = (state_d != MAIN_SKID);
  end

  // NOTE: the payload buffers are reset too, so out_data reads zero while resetl is low.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

`else

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (in_ready) begin
      // Empty slots load a zero control field so bubbles never carry stale control bits.
      valid_d = in_valid;
      ctrl_d  = in_valid ? in_ctrl : '0;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, hand sequences and a scoreboard monitor.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          resetl, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk      (clk),
    .resetl   (resetl),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  entry_t sb[$];
  entry_t popped;
  int     model_cnt = 0;

  // Scoreboard monitor: evaluates the handshake in the middle of each cycle.
  always @(negedge clk) begin
    if (!resetl) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      check("stall_cnt_track", stall_cnt, model_cnt);
      check("out_valid_track", out_valid, sb.size() != 0);
`ifdef PIPE_STAGE_SKID_EN
      check("in_ready_track", in_ready, sb.size() < 2);
`else
      check("in_ready_track", in_ready, (sb.size() == 0) || out_ready);
`endif
      if (!out_valid) check("bubble_ctrl", out_ctrl, 0);
      if (out_valid && out_ready && sb.size() != 0) begin
        popped = sb.pop_front();
        check("sb_ctrl", out_ctrl, popped.ctrl);
        check("sb_data", out_data, popped.data);
      end
      if (out_valid && !out_ready && model_cnt < (2**NW - 1)) model_cnt++;
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{ctrl: in_ctrl, data: in_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetl    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_ctrl   = '0;
    in_data   = '0;
    step();
    step();
    resetl = 1'b1;
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_out_valid", out_valid, 0);
  endtask

  typedef struct {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic [CW-1:0] e_c;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t vt[9];

  initial begin
    resetl    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_ctrl", out_ctrl, 0);
    check("reset_out_data", out_data, 0);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_in_ready", in_ready, 1);
    do_reset();

    // Streaming: 0x1..0x8 back-to-back, then one idle cycle.
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{v: 1'b1, c: CW'(8'h10 + i), d: DW'(i + 1), ordy: 1'b1,
                e_ov: 1'b1, e_c: CW'(8'h10 + i), e_d: DW'(i + 1)};
    end
    vt[8] = '{v: 1'b0, c: '0, d: '0, ordy: 1'b1, e_ov: 1'b0, e_c: '0, e_d: DW'(8)};
    for (int i = 0; i < 9; i++) begin
      in_valid  = vt[i].v;
      in_ctrl   = vt[i].c;
      in_data   = vt[i].d;
      out_ready = vt[i].ordy;
      step();
      check($sformatf("stream_ov[%0d]", i), out_valid, vt[i].e_ov);
      check($sformatf("stream_ctrl[%0d]", i), out_ctrl, vt[i].e_c);
      check($sformatf("stream_data[%0d]", i), out_data, vt[i].e_d);
    end
    check("stream_stall_cnt", stall_cnt, 0);

    // Stall: 0xA5 held for three stall cycles.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h21;
    in_data   = 64'hA5;
    step();
    check("stall_hold0", out_data, 64'hA5);
`ifdef PIPE_STAGE_SKID_EN
    in_ctrl = 8'h12;
    in_data = 64'h5A;
`else
    in_valid = 1'b0;
`endif
    step();
    in_valid = 1'b0;
    check("stall_hold1", out_data, 64'hA5);
`ifdef PIPE_STAGE_SKID_EN
    check("skid_in_ready_low", in_ready, 0);
`endif
    step();
    check("stall_hold2", out_data, 64'hA5);
    step();
    check("stall_hold3", out_data, 64'hA5);
    check("stall_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    check("stall_cnt_3", stall_cnt, 3);
`ifdef PIPE_STAGE_SKID_EN
    check("skid_emerge_valid", out_valid, 1);
    check("skid_emerge_data", out_data, 64'h5A);
    step();
`endif
    check("stall_drained", out_valid, 0);
    check("stall_drained_ctrl", out_ctrl, 0);

    // Flush while holding ctrl=0xFF with a competing incoming entry.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'hFF;
    in_data   = 64'h77;
    step();
    check("flush_pre_ctrl", out_ctrl, 8'hFF);
    flush   = 1'b1;
    in_ctrl = 8'h33;
    in_data = 64'h99;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_out_ctrl", out_ctrl, 0);
    check("flush_data_hold", out_data, 64'h77);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("flush_no_ghost[%0d]", i), out_valid, 0);
    end

    // Saturation of the 4-bit stall counter.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h05;
    in_data   = 64'hC3;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("stall_cnt_saturate", stall_cnt, 4'hF);
    out_ready = 1'b1;
    step();
    check("stall_cnt_flush_free", stall_cnt, 4'hF);

    // Asynchronous reset mid-cycle while full.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h7E;
    in_data   = 64'hDEAD;
    step();
    in_valid = 1'b0;
    step();
    #2;
    resetl = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_out_ctrl", out_ctrl, 0);
    check("areset_out_data", out_data, 0);
    check("areset_stall_cnt", stall_cnt, 0);
    check("areset_in_ready", in_ready, 1);
    step();
    resetl    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 8'h42;
    in_data   = 64'hBEEF;
    step();
    in_valid = 1'b0;
    check("areset_first_valid", out_valid, 1);
    check("areset_first_data", out_data, 64'hBEEF);
    step();

    // Random valid/ready/flush traffic checked by the scoreboard monitor.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 64) == 0;
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom};
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("random_drain", sb.size(), 0);
    check("random_drain_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
